// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: converts one load/store into 1-2 word-aligned bus beats.
// Ports: clk/rst, req_* (captured request), stall/rdata/misalign_err (to core), bus_* (memory side).
// Macro DMEM_MISALIGNED_SPLIT_EN: when defined, misaligned accesses are split into two beats;
// when undefined, they retire immediately with a one-cycle misalign_err pulse and no bus traffic.
module dmem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_mask,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

`ifdef DMEM_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    DONE
  } state_t;

  state_t state, state_nx;

  // captured request
  logic        we_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic        split_q;
  logic        err_q;
  logic [3:0]  mask1_q;
  logic [31:0] data_q;

  // registered bus outputs
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_mask_q;

  // request decode
  logic [1:0]  off_in;
  logic [7:0]  base_in;
  logic [7:0]  span_in;
  logic        split_in;

  function automatic logic [31:0] rotl8(
    input logic [31:0] d,
    input logic [1:0]  o
  );
    logic [31:0] r;
    unique case (o)
      2'd0:    r = d;
      2'd1:    r = {d[23:0], d[31:24]};
      2'd2:    r = {d[15:0], d[31:16]};
      default: r = {d[7:0], d[31:8]};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rotr8(
    input logic [31:0] d,
    input logic [1:0]  o
  );
    logic [31:0] r;
    unique case (o)
      2'd0:    r = d;
      2'd1:    r = {d[7:0], d[31:8]};
      2'd2:    r = {d[15:0], d[31:16]};
      default: r = {d[23:0], d[31:24]};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] bytes(
    input logic [3:0] m
  );
    return {{8{m[3]}}, {8{m[2]}},
            {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic logic [31:0] extend(
    input logic [31:0] d,
    input logic [1:0]  sz,
    input logic        sg
  );
    logic [31:0] r;
    unique case (sz)
      2'b00:   r = {{24{sg & d[7]}}, d[7:0]};
      2'b01:   r = {{16{sg & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // The access footprint over two consecutive words: the low
  // nibble is beat 0, the high nibble spills into the next word.
  always_comb begin
    off_in = req_addr[1:0];
    unique case (req_size)
      2'b00:   base_in = 8'h01;
      2'b01:   base_in = 8'h03;
      default: base_in = 8'h0F;
    endcase
    span_in  = base_in << off_in;
    split_in = |span_in[7:4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (split_in && !SPLIT_EN) state_nx = DONE;
          else                       state_nx = BEAT0;
        end
      end
      BEAT0: begin
        if (bus_ready) begin
          if (split_q && SPLIT_EN) state_nx = BEAT1;
          else                     state_nx = DONE;
        end
      end
      BEAT1: begin
        if (bus_ready) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q        <= 1'b0;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      sgn_q       <= 1'b0;
      split_q     <= 1'b0;
      err_q       <= 1'b0;
      mask1_q     <= 4'd0;
      data_q      <= 32'd0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_mask_q  <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            off_q       <= off_in;
            size_q      <= req_size;
            sgn_q       <= req_signed;
            split_q     <= split_in;
            err_q       <= split_in & ~SPLIT_EN;
            mask1_q     <= span_in[7:4];
            data_q      <= 32'd0;
            bus_we_q    <= req_we;
            bus_addr_q  <= {req_addr[31:2], 2'b00};
            bus_wdata_q <= rotl8(req_wdata, off_in);
            bus_mask_q  <= span_in[3:0];
          end
        end
        BEAT0: begin
          if (bus_ready) begin
            data_q <= bus_rdata & bytes(bus_mask_q);
            if (split_q && SPLIT_EN) begin
              // wraps from 0xFFFFFFFC to 0 naturally
              bus_addr_q <= bus_addr_q + 32'd4;
              bus_mask_q <= mask1_q;
            end
          end
        end
        BEAT1: begin
          if (bus_ready) begin
            data_q <= data_q
                    | (bus_rdata & bytes(bus_mask_q));
          end
        end
        default: ;
      endcase
    end
  end

  assign stall        = req_valid && (state != DONE);
  assign bus_valid    = (state == BEAT0) || (state == BEAT1);
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_mask     = bus_mask_q;
  assign misalign_err = (state == DONE) && err_q;

  // data_q is cleared on capture, so rejected accesses read 0
  assign rdata = we_q ? 32'd0
               : extend(rotr8(data_q, off_q), size_q, sgn_q);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed loads/stores,
// bus beats and retire responses checked by a negedge monitor.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        stall;
  logic [31:0] rdata;
  logic        misalign_err;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_mask;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  dmem_access_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .stall        (stall),
    .rdata        (rdata),
    .misalign_err (misalign_err),
    .bus_valid    (bus_valid),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_mask     (bus_mask),
    .bus_ready    (bus_ready),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } resp_t;

  beat_t       beat_q[$];
  resp_t       resp_q[$];
  logic [31:0] rd_q[$];

  int compared   = 0;
  int mismatched = 0;
  int ready_wait = 0;
  int done_cnt   = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic exp_beat(input logic we,
                          input logic [31:0] addr,
                          input logic [3:0] mask,
                          input logic [31:0] wdata,
                          input logic [31:0] rd);
    beat_t b;
    b.we = we; b.addr = addr;
    b.mask = mask; b.wdata = wdata;
    beat_q.push_back(b);
    rd_q.push_back(rd);
  endtask

  task automatic exp_resp(input logic [31:0] rd,
                          input logic err,
                          input int stalls);
    resp_t r;
    r.rdata = rd; r.err = err; r.stalls = stalls;
    resp_q.push_back(r);
  endtask

  // bus responder + monitor, one decision per negedge
  task automatic monitor();
    int    wait_cnt  = 0;
    int    stall_cnt = 0;
    beat_t b;
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus_ready = 1'b0;
        wait_cnt  = 0;
        stall_cnt = 0;
        continue;
      end
      if (bus_valid) begin
        if (wait_cnt < ready_wait) begin
          bus_ready = 1'b0;
          wait_cnt++;
        end else begin
          bus_ready = 1'b1;
          wait_cnt  = 0;
          bus_rdata = (rd_q.size() > 0)
                    ? rd_q.pop_front() : 32'h0;
        end
        if (beat_q.size() == 0) begin
          chk("unexpected_bus_valid", 32'(bus_valid), 32'd0);
        end else begin
          if (bus_ready) b = beat_q.pop_front();
          else           b = beat_q[0];
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_mask", 32'(bus_mask), 32'(b.mask));
          chk("bus_we", 32'(bus_we), 32'(b.we));
          if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
        end
      end else begin
        bus_ready = 1'b0;
        wait_cnt  = 0;
      end
      if (stall) stall_cnt++;
      if (req_valid && !stall) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          r = resp_q.pop_front();
          chk("rdata", rdata, r.rdata);
          chk("misalign_err", 32'(misalign_err), 32'(r.err));
          chk("stall_cycles", 32'(stall_cnt), 32'(r.stalls));
          chk("done_bus_valid", 32'(bus_valid), 32'd0);
        end
        stall_cnt = 0;
        done_cnt++;
      end else if (misalign_err) begin
        chk("misalign_err_outside_done", 32'd1, 32'd0);
      end
    end
  endtask

  task automatic recover();
    rst = 1'b1;
    req_valid = 1'b0;
    beat_q.delete();
    resp_q.delete();
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // request held until retire; req_* scrambled after capture
  task automatic issue(input logic we,
                       input logic [31:0] addr,
                       input logic [31:0] wdata,
                       input logic [1:0] size,
                       input logic sgn,
                       input int wt);
    int d0;
    int n;
    ready_wait = wt;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_size   = size;
    req_signed = sgn;
    d0 = done_cnt;
    @(posedge clk); #1;
    req_we     = ~we;
    req_addr   = ~addr;
    req_wdata  = ~wdata;
    req_size   = ~size;
    req_signed = ~sgn;
    n = 0;
    while (done_cnt == d0 && n < 40) begin
      @(negedge clk); #2;
      n++;
    end
    if (done_cnt == d0) begin
      chk("retire_timeout", 32'd0, 32'd1);
      recover();
    end else begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    bus_ready  = 1'b0;
    bus_rdata  = 32'h0;
    fork
      monitor();
    join_none

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_mask", 32'(bus_mask), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_misalign_err", 32'(misalign_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_bus_valid", 32'(bus_valid), 32'd0);

    // lw 0x100, ready same cycle
    exp_beat(1'b0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    exp_resp(32'hDEADBEEF, 1'b0, 2);
    issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 0);

    // lb 0x203 signed / unsigned
    exp_beat(1'b0, 32'h200, 4'b1000, 32'h0, 32'h80000000);
    exp_resp(32'hFFFFFF80, 1'b0, 2);
    issue(1'b0, 32'h203, 32'h0, 2'b00, 1'b1, 0);
    exp_beat(1'b0, 32'h200, 4'b1000, 32'h0, 32'h80000000);
    exp_resp(32'h00000080, 1'b0, 2);
    issue(1'b0, 32'h203, 32'h0, 2'b00, 1'b0, 0);

    // sh 0x302, ready held low 3 cycles
    exp_beat(1'b1, 32'h300, 4'b1100, 32'hABCD0000, 32'h0);
    exp_resp(32'h0, 1'b0, 5);
    issue(1'b1, 32'h302, 32'h0000ABCD, 2'b01, 1'b0, 3);

    // lhu 0x502
    exp_beat(1'b0, 32'h500, 4'b1100, 32'h0, 32'h87654321);
    exp_resp(32'h00008765, 1'b0, 2);
    issue(1'b0, 32'h502, 32'h0, 2'b01, 1'b0, 0);

    // size 11 as word, one wait cycle
    exp_beat(1'b0, 32'h600, 4'b1111, 32'h0, 32'h12345678);
    exp_resp(32'h12345678, 1'b0, 3);
    issue(1'b0, 32'h600, 32'h0, 2'b11, 1'b1, 1);

    // lb 0x701 signed, positive byte
    exp_beat(1'b0, 32'h700, 4'b0010, 32'h0, 32'h00007F00);
    exp_resp(32'h0000007F, 1'b0, 2);
    issue(1'b0, 32'h701, 32'h0, 2'b00, 1'b1, 0);

    // sb 0x802
    exp_beat(1'b1, 32'h800, 4'b0100, 32'h00A50000, 32'h0);
    exp_resp(32'h0, 1'b0, 2);
    issue(1'b1, 32'h802, 32'h000000A5, 2'b00, 1'b0, 0);

`ifdef DMEM_MISALIGNED_SPLIT_EN
    // sw 0xFFFFFFFD split with address wrap
    exp_beat(1'b1, 32'hFFFFFFFC, 4'b1110, 32'h22334411, 32'h0);
    exp_beat(1'b1, 32'h00000000, 4'b0001, 32'h22334411, 32'h0);
    exp_resp(32'h0, 1'b0, 3);
    issue(1'b1, 32'hFFFFFFFD, 32'h11223344, 2'b10, 1'b0, 0);
    // lh 0x403 split load
    exp_beat(1'b0, 32'h400, 4'b1000, 32'h0, 32'hAB000000);
    exp_beat(1'b0, 32'h404, 4'b0001, 32'h0, 32'h000000CD);
    exp_resp(32'hFFFFCDAB, 1'b0, 3);
    issue(1'b0, 32'h403, 32'h0, 2'b01, 1'b1, 0);
`else
    // misaligned: retire at once with error pulse
    exp_resp(32'h0, 1'b1, 1);
    issue(1'b1, 32'hFFFFFFFD, 32'h11223344, 2'b10, 1'b0, 0);
    exp_resp(32'h0, 1'b1, 1);
    issue(1'b0, 32'h403, 32'h0, 2'b01, 1'b1, 0);
`endif

    // aligned word after misaligned traffic
    exp_beat(1'b0, 32'h900, 4'b1111, 32'h0, 32'hCAFEF00D);
    exp_resp(32'hCAFEF00D, 1'b0, 2);
    issue(1'b0, 32'h900, 32'h0, 2'b10, 1'b0, 0);

    // reset during BEAT0 with bus_ready low
    ready_wait = 100;
    exp_beat(1'b0, 32'hA00, 4'b1111, 32'h0, 32'h0);
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'hA00;
    req_size   = 2'b10;
    req_signed = 1'b0;
    @(posedge clk); #1;
    chk("beat0_bus_valid", 32'(bus_valid), 32'd1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("async_rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("async_rst_bus_mask", 32'(bus_mask), 32'd0);
    beat_q.delete();
    rd_q.delete();
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ready_wait = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_bus_valid", 32'(bus_valid), 32'd0);
    end
    chk("post_rst_misalign_err", 32'(misalign_err), 32'd0);

    repeat (3) @(posedge clk);
    chk("beats_left", 32'(beat_q.size()), 32'd0);
    chk("resps_left", 32'(resp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
